key_pad_emu: RTL and testbench

KEY_PAD_EMU -- requirements
Module: key_pad_emu

---
 rtl/key_pad_emu_pkg.sv | 36 +++
 rtl/key_cmd_fifo.sv | 54 +++++
 rtl/key_pad_emu.sv | 103 ++++++++++
 tb/tb_key_pad_emu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pad_emu_pkg.sv
// Shared types and decode helpers for the keypad emulator.
// A key code maps to a one-hot row (code / 3) and a one-hot column (code % 3).
package key_pad_emu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int KEY_ROWS = 4;
   localparam int KEY_COLS = 3;
   localparam int CODE_W   = 4;
   localparam int HOLD_W   = 8;
   localparam int ENTRY_W  = CODE_W + HOLD_W;
   localparam int MAX_CODE = KEY_ROWS * KEY_COLS - 1;

   function automatic logic [KEY_ROWS-1:0] code_to_row(input logic [CODE_W-1:0] code);
      logic [KEY_ROWS-1:0] r;
      r = '0;
      for (int i = 0; i < KEY_ROWS; i++) begin
         if (int'(code) / KEY_COLS == i) r[i] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [KEY_COLS-1:0] code_to_col(input logic [CODE_W-1:0] code);
      logic [KEY_COLS-1:0] c;
      c = '0;
      for (int i = 0; i < KEY_COLS; i++) begin
         if (int'(code) % KEY_COLS == i) c[i] = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/key_cmd_fifo.sv
// Command queue for key-press entries: synchronous push/pop with show-ahead head.
// A push is ignored while full and a pop is ignored while empty.
module key_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [DEPTH:0] DEPTH_C = (DEPTH + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [DEPTH:0]   count;
   logic             do_wr;
   logic             do_rd;

   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/key_pad_emu.sv
// Keypad emulator: queued key presses drive one-hot row lines in answer to the
// scanner's column strobe, each press followed by a fixed all-rows-low release gap.
module key_pad_emu
   import key_pad_emu_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int RELEASE_CYCLES = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [KEY_COLS-1:0] key_pad_col,
   input  logic                push,
   input  logic [CODE_W-1:0]   push_code,
   input  logic [HOLD_W-1:0]   push_hold,
   output logic [KEY_ROWS-1:0] key_pad_row,
   output logic                full,
   output logic                busy,
   output logic                done,
   output logic                err,
   output state_t              fsm_state
);

   localparam int REL_W = $clog2(RELEASE_CYCLES + 1);

   state_t              state;
   logic [KEY_ROWS-1:0] cur_row;
   logic [KEY_COLS-1:0] cur_col;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [REL_W-1:0]    rel_cnt;
   logic [ENTRY_W-1:0]  head;
   logic [CODE_W-1:0]   head_code;
   logic [HOLD_W-1:0]   head_hold;
   logic                empty;
   logic                push_ok;
   logic                push_bad;
   logic                pop;

   assign push_ok   = push && !full && (push_code <= CODE_W'(MAX_CODE));
   assign push_bad  = push && !push_ok;
   assign pop       = (state == IDLE) && !empty;
   assign head_code = head[ENTRY_W-1:HOLD_W];
   assign head_hold = head[HOLD_W-1:0];
   assign busy      = (state != IDLE) || !empty;
   assign fsm_state = state;

   key_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_ok),
      .wr_data ({push_code, push_hold}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cur_row     <= '0;
         cur_col     <= '0;
         hold_cnt    <= '0;
         rel_cnt     <= '0;
         key_pad_row <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (push_bad) err <= 1'b1;
         // Exact match only: an idle, empty or multi-hot strobe never equals a one-hot cur_col.
         key_pad_row <= (state == PRESS && key_pad_col == cur_col) ? cur_row : '0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  cur_row  <= code_to_row(head_code);
                  cur_col  <= code_to_col(head_code);
                  hold_cnt <= (head_hold == '0) ? HOLD_W'(1) : head_hold;
                  state    <= PRESS;
               end
            end
            PRESS: begin
               hold_cnt <= hold_cnt - 1'b1;
               if (hold_cnt == HOLD_W'(1)) begin
                  rel_cnt <= REL_W'(RELEASE_CYCLES);
                  state   <= RELEASE;
               end
            end
            RELEASE: begin
               rel_cnt <= rel_cnt - 1'b1;
               if (rel_cnt == REL_W'(1)) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_pad_emu.sv
// Directed bench for key_pad_emu: hand-computed rows, state timing, done pulses,
// FIFO overflow, invalid codes and asynchronous reset.
module tb_key_pad_emu;
   import key_pad_emu_pkg::*;

   logic        clk;
   logic        reset;
   logic [2:0]  key_pad_col;
   logic        push;
   logic [3:0]  push_code;
   logic [7:0]  push_hold;
   logic [3:0]  key_pad_row;
   logic        full;
   logic        busy;
   logic        done;
   logic        err;
   state_t      fsm_state;

   int          check_cnt = 0;
   int          pass_cnt  = 0;
   logic [3:0]  exp_q[$];

   key_pad_emu #(
      .FIFO_DEPTH     (4),
      .RELEASE_CYCLES (6)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_pad_col (key_pad_col),
      .push        (push),
      .push_code   (push_code),
      .push_hold   (push_hold),
      .key_pad_row (key_pad_row),
      .full        (full),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .fsm_state   (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      push  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic push_cmd(input logic [3:0] code, input logic [7:0] hold);
      push      = 1'b1;
      push_code = code;
      push_hold = hold;
      tick();
      push      = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cycles);
      int   n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (n < max_cycles && !seen) begin
         if (done) seen = 1'b1;
         else begin
            tick();
            n++;
         end
      end
      check(tag, seen, 1'b1);
   endtask

   initial begin
      logic [3:0] exp_row;
      logic [2:0] col;
      state_t     exp_st;
      int         done_cnt;
      int         busy_seen;
      logic [3:0] codes [4];
      logic [3:0] rows  [4];
      logic [2:0] cols  [4];
      logic [2:0] bad_cols [3];

      codes = '{4'd0, 4'd2, 4'd9, 4'd11};
      rows  = '{4'b0001, 4'b0001, 4'b1000, 4'b1000};
      cols  = '{3'b001, 3'b100, 3'b001, 3'b100};
      bad_cols = '{3'b011, 3'b000, 3'b111};

      reset       = 1'b0;
      push        = 1'b0;
      push_code   = '0;
      push_hold   = '0;
      key_pad_col = '0;
      #12;
      check("rst_row", key_pad_row, 4'b0000);
      check("rst_full", full, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_state", fsm_state, IDLE);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // single key 4 (row1/col1), hold 10, cycling column strobe
      push_cmd(4'd4, 8'd10);
      check("single_busy_queued", busy, 1'b1);
      check("single_idle_before_press", fsm_state, IDLE);
      tick();
      exp_row = 4'b0000;
      for (int i = 0; i <= 16; i++) begin
         exp_st = (i < 10) ? PRESS : (i < 16) ? RELEASE : IDLE;
         check("single_state", fsm_state, exp_st);
         check("single_row", key_pad_row, exp_row);
         check("single_done", done, (i == 16));
         col         = 3'b001 << (i % 3);
         key_pad_col = col;
         exp_row     = (i <= 9 && col == 3'b010) ? 4'b0010 : 4'b0000;
         tick();
      end
      check("single_busy_after", busy, 1'b0);

      // corner keys
      for (int k = 0; k < 4; k++) begin
         key_pad_col = cols[k];
         exp_q.push_back(rows[k]);
         push_cmd(codes[k], 8'd3);
         tick();
         tick();
         check("corner_row", key_pad_row, exp_q.pop_front());
         wait_done("corner_done", 20);
         check("corner_row_released", key_pad_row, 4'b0000);
         tick();
      end
      check("corner_err_clear", err, 1'b0);

      // empty and multi-hot strobes never match
      key_pad_col = 3'b011;
      push_cmd(4'd4, 8'd4);
      tick();
      for (int i = 0; i < 5; i++) begin
         key_pad_col = bad_cols[i % 3];
         tick();
         check("multihot_row", key_pad_row, 4'b0000);
      end
      wait_done("multihot_done", 20);

      // invalid codes
      reset_dut();
      push_cmd(4'd13, 8'd5);
      check("inv13_err", err, 1'b1);
      check("inv13_busy", busy, 1'b0);
      repeat (3) tick();
      check("inv13_busy_later", busy, 1'b0);
      check("inv13_row", key_pad_row, 4'b0000);
      check("inv13_state", fsm_state, IDLE);
      reset_dut();
      check("err_cleared_by_reset", err, 1'b0);
      push_cmd(4'd12, 8'd5);
      check("inv12_err", err, 1'b1);
      check("inv12_busy", busy, 1'b0);

      // hold = 0 behaves as a single press cycle
      reset_dut();
      key_pad_col = 3'b010;
      push_cmd(4'd7, 8'd0);
      tick();
      check("hold0_press", fsm_state, PRESS);
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp_st = (i <= 6) ? RELEASE : IDLE;
         check("hold0_state", fsm_state, exp_st);
         check("hold0_done", done, (i == 7));
         if (i == 1) check("hold0_row", key_pad_row, 4'b0100);
      end

      // overflow: a long press keeps the FSM away from IDLE while the queue fills
      reset_dut();
      key_pad_col = 3'b000;
      push_cmd(4'd0, 8'd40);
      tick();
      check("ovf_blocker_press", fsm_state, PRESS);
      for (int k = 0; k < 5; k++) begin
         push_cmd(4'(k + 1), 8'd2);
         check("ovf_full", full, (k >= 3));
         check("ovf_err", err, (k == 4));
      end
      done_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         if (done) done_cnt++;
         tick();
      end
      check("ovf_done_count", done_cnt, 5);
      check("ovf_full_after", full, 1'b0);
      check("ovf_busy_after", busy, 1'b0);

      // asynchronous reset in the middle of a press
      reset_dut();
      key_pad_col = 3'b100;
      push_cmd(4'd5, 8'd20);
      push_cmd(4'd3, 8'd20);
      check("rstmid_press", fsm_state, PRESS);
      tick();
      check("rstmid_row_active", key_pad_row, 4'b0010);
      #2;
      reset = 1'b0;
      #1;
      check("rstmid_row", key_pad_row, 4'b0000);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_full", full, 1'b0);
      check("rstmid_state", fsm_state, IDLE);
      @(negedge clk);
      reset     = 1'b1;
      done_cnt  = 0;
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) done_cnt++;
         if (busy) busy_seen++;
      end
      check("rstmid_no_done", done_cnt, 0);
      check("rstmid_no_busy", busy_seen, 0);
      check("rstmid_row_idle", key_pad_row, 4'b0000);

      // report
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
